event_pulse_driver: RTL

//  Output-side counterpart of the button-input debouncer: converts 1-cycle event pulses from the vending
//  FSM (dispense, coin return, buzzer) into timed drive pulses for solenoids/LEDs. Each accepted event

---
 rtl/vending_io_pkg.sv | 17 +
 rtl/cycle_timer.sv | 35 +++
 rtl/event_pulse_driver.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vending_io_pkg.sv
// Shared vending-machine I/O types and timing defaults, used by the FSM and the actuator drivers.
package vending_io_pkg;

    typedef enum logic [1:0] {IDLE, ON, GAP} pulse_state_t;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DISPENSE_ON_CYCLES  = CLK_HZ / 2;
    localparam int DISPENSE_OFF_CYCLES = CLK_HZ / 4;

    // Phase timer must hold the longer of the two phase lengths.
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        int longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/event_pulse_driver.sv
// Timed actuator pulse driver: each accepted event gives one ON_CYCLES pulse plus an OFF_CYCLES gap.
// Define PULSE_QUEUE_EN to queue events arriving while busy; without it such events are dropped.
module event_pulse_driver
    import vending_io_pkg::*;
#(
    parameter int ON_CYCLES  = DISPENSE_ON_CYCLES,
    parameter int OFF_CYCLES = DISPENSE_OFF_CYCLES,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    input  logic              clear,
    output logic              drive_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    localparam int              TW       = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0]   ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]   OFF_LOAD = TW'(OFF_CYCLES - 1);

    pulse_state_t  state_q;
    pulse_state_t  state_d;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;
    logic          drive_q, drive_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic          gap_end;
    logic          queued;
    logic          direct_start;

    cycle_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    assign gap_end      = (state_q == GAP) && timer_done;
    assign direct_start = trigger && ((state_q == IDLE) || (gap_end && !queued));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase sequencing; a queued event or a coincident trigger chains straight from GAP into ON.
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_val  = ON_LOAD;
        if (clear) begin
            state_d    = IDLE;
            timer_load = 1'b1;
            timer_val  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_d    = ON;
                        timer_load = 1'b1;
                    end
                end
                ON: begin
                    if (timer_done) begin
                        state_d    = GAP;
                        timer_load = 1'b1;
                        timer_val  = OFF_LOAD;
                    end
                end
                GAP: begin
                    if (timer_done) begin
                        if (queued || trigger) begin
                            state_d    = ON;
                            timer_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        drive_d = (state_d == ON);
        busy_d  = (state_d != IDLE);
    end

`ifdef PULSE_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0] pending_q, pending_d;
    logic              inc, dec;

    assign queued = (pending_q != '0);
    assign inc    = trigger && !direct_start;
    assign dec    = gap_end && queued;

    // Simultaneous enqueue and dequeue cancel, so a full queue still accepts that trigger.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (clear) begin
            pending_d  = '0;
            overflow_d = 1'b0;
        end else if (inc && !dec) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (dec && !inc) begin
            pending_d = pending_q - PEND_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`else
    assign queued = 1'b0;

    always_comb begin
        overflow_d = overflow_q;
        if (clear) begin
            overflow_d = 1'b0;
        end else if (trigger && !direct_start) begin
            overflow_d = 1'b1;
        end
    end

    assign pending = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            drive_q    <= drive_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign drive_out = drive_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule
